hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
- Execute-stage producer for the HI/LO register file.
- Runs MULT/MULTU/DIV/DIVU iteratively over 32 cycles and passes MTHI/MTLO straight through.
- Drives the EX-stage HI/LO write-enable and data signals that feed HI/LO forwarding and writeback.
- Raises a stall request to the pipeline stall controller while an iterative operation is in flight.

Parameters:
- ITER, 32, number of iteration cycles for multiply and divide (operand width; fixed at 32).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of the current operation; no HI/LO write results.
- ex_hold  in  1  EX stage frozen by a downstream stall; a completed result is held.
- op_valid  in  1  EX holds a valid HI/LO-writing instruction.
- op  in  3  operation code (see package).
- src_a  in  32  rs operand: multiplicand/dividend, or MTHI/MTLO data.
- src_b  in  32  rt operand: multiplier/divisor.
- stallreq  out  1  request to stall IF..EX.
- hi_we  out  1  HI write enable for this EX cycle.
- lo_we  out  1  LO write enable for this EX cycle.
- hi_out  out  32  HI write data.
- lo_out  out  32  LO write data.

Behaviour:
- Reset: async on rst_n low. State=IDLE, counter=0, accumulators=0. stallreq=0, hi_we=0, lo_we=0, hi_out=0, lo_out=0.
- States: IDLE, CALC, DONE.
- IDLE, MTHI/MTLO with op_valid:
  - Combinational, same cycle, no stall.
  - MTHI: hi_we=1, hi_out=src_a.
  - MTLO: lo_we=1, lo_out=src_a.
  - State stays IDLE.
- IDLE, MULT/MULTU/DIV/DIVU with op_valid (start cycle T):
  - Capture |a| and |b| (unsigned ops: raw values) and the sign flags.
  - stallreq=1 combinationally in cycle T. Go to CALC with counter=0.
- Divide by zero, DIV/DIVU with src_b=0:
  - Skip CALC and go to DONE at T+1.
  - Result: hi_out=src_a, lo_out=32'hFFFFFFFF, no sign fixup.
- CALC:
  - stallreq=1. One radix-2 step per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring, 33-bit partial remainder.
  - Counter runs 0..ITER-1. At counter=ITER-1, go to DONE. op_valid/op/src are ignored.
- DONE (normally T+33):
  - stallreq=0, hi_we=lo_we=1, hi_out/lo_out = fixed-up result, all registered.
  - Signed fixup, multiply: negate the 64-bit product if the signs differ.
  - Signed fixup, divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Result placement: mul gives {hi,lo}=product; div gives hi=remainder, lo=quotient.
  - If ex_hold=1, stay in DONE holding outputs. Otherwise go to IDLE next cycle.
  - The op_valid still asserted in the DONE cycle is consumed and does not restart the unit.
- Total stallreq-high cycles for a normal mul/div: 33 (T..T+32).
- Width edge case: |0x80000000| = 0x80000000 unsigned. DIV 0x80000000/0xFFFFFFFF yields lo=0x80000000, hi=0.
- flush:
  - Any state goes to IDLE next edge; write enables are 0 in the flush cycle.
  - flush has priority over start; an op presented with flush is not started.
- rst_n low mid-operation: immediate return to reset state; outputs 0.
- Outputs are 0 when no write is in progress.
- op_valid with op=NONE: no effect.

Decomposition:
- Shared package holds:
  - op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6;
  - state encoding: IDLE=0, CALC=1, DONE=2;
  - ITER.
- Existing defines.vh supplies the Stop/NoStop values used for stallreq.
- One natural sub-module: hilo_div_step, the combinational single restoring step (33-bit remainder in, shifted dividend bit, divisor → next remainder, quotient bit). The multiply step stays inline.

Test Plan:
- MULT src_a=32'hFFFFFFFD (-3), src_b=7 → stallreq high 33 cycles, then one DONE cycle with hi_out=FFFFFFFF, lo_out=FFFFFFEB, hi_we=lo_we=1.
- MULTU FFFFFFFF×FFFFFFFF → hi=FFFFFFFE, lo=00000001. DIVU 100/7 → hi=2, lo=14.
- DIV -7/2 (FFFFFFF9, 2) → lo=FFFFFFFD, hi=FFFFFFFF. DIV 80000000/FFFFFFFF → lo=80000000, hi=0.
- DIVU 5/0 → DONE at T+1 with hi=5, lo=FFFFFFFF. MTHI 0x1234 → same-cycle hi_we=1, hi_out=1234, stallreq=0.
- DIV started, flush at T+10 → IDLE next edge, no hi_we/lo_we ever asserted. Repeat with rst_n pulsed low at T+5 → all outputs 0 immediately.
- MULT done with ex_hold=1 for 3 cycles → DONE outputs held stable 4 cycles, single completion, then IDLE with no restart while op_valid is still high in the DONE cycle.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// ============================================================================
// hilo_muldiv_pkg : op codes, FSM states and constants shared by the HI/LO unit
// Rev 1.0
// ============================================================================
`default_nettype none

package hilo_muldiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  // Stall request levels seen by the pipeline stall controller
  localparam logic c_STOP    = 1'b1;
  localparam logic c_NO_STOP = 1'b0;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_iter_op(input op_e o);
    return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_div_step.sv
// ============================================================================
// hilo_div_step : one combinational restoring-division step
// Rev 1.0
// ============================================================================
`default_nettype none

module hilo_div_step (
  input  logic [31:0] rem_i,
  input  logic        bit_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic        q_o
);

  logic [32:0] part_w;
  logic [32:0] diff_w;

  assign part_w = {rem_i, bit_i};
  assign diff_w = part_w - {1'b0, divisor_i};

  // rem_i < divisor keeps part_w < 2*divisor, so bit 32 of the difference is exactly the borrow
  assign q_o   = ~diff_w[32];
  assign rem_o = q_o ? diff_w[31:0] : part_w[31:0];

endmodule

`default_nettype wire

// File: rtl/hilo_muldiv.sv
// ============================================================================
// hilo_muldiv : EX-stage HI/LO producer, iterative mul/div plus MTHI/MTLO pass-through
// Rev 1.0
// ============================================================================
`default_nettype none

module hilo_muldiv
  import hilo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        ex_hold,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stallreq,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(ITER - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      acc_q;
  logic [31:0]      opb_q;
  logic             is_div_q;
  logic             neg_q;
  logic             remneg_q;
  logic [31:0]      res_hi_q;
  logic [31:0]      res_lo_q;

  op_e         op_w;
  logic        go_w, start_w, mthi_w, mtlo_w, done_w;
  logic        signed_w, div_op_w;
  logic [31:0] abs_a_w, abs_b_w;
  logic [32:0] msum_w;
  logic [31:0] drem_w;
  logic        dq_w;
  logic [63:0] acc_d;
  logic [63:0] prod_fix_w;
  logic [31:0] quo_fix_w, rem_fix_w;
  logic [31:0] fin_hi_w, fin_lo_w;

  assign op_w     = op_e'(op);
  assign go_w     = op_valid && !flush && (state_q == ST_IDLE);
  assign start_w  = go_w && is_iter_op(op_w);
  assign mthi_w   = go_w && (op_w == OP_MTHI);
  assign mtlo_w   = go_w && (op_w == OP_MTLO);
  assign done_w   = !flush && (state_q == ST_DONE);

  assign signed_w = (op_w == OP_MULT) || (op_w == OP_DIV);
  assign div_op_w = (op_w == OP_DIV) || (op_w == OP_DIVU);
  assign abs_a_w  = (signed_w && src_a[31]) ? -src_a : src_a;
  assign abs_b_w  = (signed_w && src_b[31]) ? -src_b : src_b;

  // Multiply: multiplier sits in acc[31:0], partial product grows from the top
  assign msum_w = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'd0)};

  hilo_div_step u_div_step (
    .rem_i     (acc_q[63:32]),
    .bit_i     (acc_q[31]),
    .divisor_i (opb_q),
    .rem_o     (drem_w),
    .q_o       (dq_w)
  );

  assign acc_d = is_div_q ? {drem_w, acc_q[30:0], dq_w} : {msum_w, acc_q[31:1]};

  assign prod_fix_w = neg_q    ? -acc_d        : acc_d;
  assign quo_fix_w  = neg_q    ? -acc_d[31:0]  : acc_d[31:0];
  assign rem_fix_w  = remneg_q ? -acc_d[63:32] : acc_d[63:32];
  assign fin_hi_w   = is_div_q ? rem_fix_w : prod_fix_w[63:32];
  assign fin_lo_w   = is_div_q ? quo_fix_w : prod_fix_w[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      remneg_q <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_w) begin
            opb_q    <= abs_b_w;
            is_div_q <= div_op_w;
            neg_q    <= signed_w && (src_a[31] ^ src_b[31]);
            remneg_q <= signed_w && div_op_w && src_a[31];
            cnt_q    <= '0;
            if (div_op_w && (src_b == 32'd0)) begin
              res_hi_q <= src_a;
              res_lo_q <= 32'hFFFF_FFFF;
              state_q  <= ST_DONE;
            end else begin
              acc_q   <= {32'd0, abs_a_w};
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == c_LAST) begin
            res_hi_q <= fin_hi_w;
            res_lo_q <= fin_lo_w;
            cnt_q    <= '0;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!ex_hold) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stallreq = ((state_q == ST_CALC) || start_w) ? c_STOP : c_NO_STOP;
  assign hi_we    = done_w || mthi_w;
  assign lo_we    = done_w || mtlo_w;
  assign hi_out   = done_w ? res_hi_q : (mthi_w ? src_a : 32'd0);
  assign lo_out   = done_w ? res_lo_q : (mtlo_w ? src_a : 32'd0);

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
// ============================================================================
// tb_hilo_muldiv : randomized self-checking bench against an arithmetic HI/LO model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hilo_muldiv;

  localparam logic [2:0] c_NONE  = 3'd0;
  localparam logic [2:0] c_MULT  = 3'd1;
  localparam logic [2:0] c_MULTU = 3'd2;
  localparam logic [2:0] c_DIV   = 3'd3;
  localparam logic [2:0] c_DIVU  = 3'd4;
  localparam logic [2:0] c_MTHI  = 3'd5;
  localparam logic [2:0] c_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n, flush, ex_hold, op_valid;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        stallreq, hi_we, lo_we;
  logic [31:0] hi_out, lo_out;

  int checks   = 0;
  int failures = 0;

  hilo_muldiv dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .ex_hold  (ex_hold),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .stallreq (stallreq),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {hi, lo} as the architecture defines it, computed with plain 64-bit arithmetic
  function automatic logic [63:0] ref_hilo(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      c_MULT:  return 64'(sa * sb);
      c_MULTU: return ua * ub;
      c_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      c_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [63:0] exp;
    int          exp_stall, nstall;
    logic        we_bad;
    exp       = ref_hilo(o, a, b);
    exp_stall = ((o == c_DIV || o == c_DIVU) && b == 32'd0) ? 1 : 33;
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    nstall = 0;
    we_bad = 1'b0;
    while (stallreq === 1'b1 && nstall < 40) begin
      nstall++;
      if (hi_we !== 1'b0 || lo_we !== 1'b0) we_bad = 1'b1;
      @(posedge clk); #1;
      src_a = $urandom; src_b = $urandom; op = 3'($urandom_range(0, 6));
      #1;
    end
    check_val("stall_cycles", 64'(nstall), 64'(exp_stall));
    check_val("we_during_stall", {63'd0, we_bad}, 64'd0);
    check_val("done_we", {62'd0, hi_we, lo_we}, 64'd3);
    check_val("done_hilo", {hi_out, lo_out}, exp);
    ex_hold = (hold > 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (h == hold - 1) ex_hold = 1'b0;
      #1;
      check_val("held_we", {62'd0, hi_we, lo_we}, 64'd3);
      check_val("held_hilo", {hi_out, lo_out}, exp);
    end
    @(posedge clk); #1;
    op_valid = 1'b0; ex_hold = 1'b0;
    #1;
    check_val("idle_ctl", {61'd0, stallreq, hi_we, lo_we}, 64'd0);
    check_val("idle_out", {hi_out, lo_out}, 64'd0);
    @(posedge clk); #2;
    check_val("no_restart", {63'd0, stallreq}, 64'd0);
  endtask

  task automatic run_mt(input logic [2:0] o, input logic [31:0] a);
    logic is_hi;
    is_hi = (o == c_MTHI);
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; src_a = a; src_b = $urandom;
    #1;
    check_val("mt_we", {62'd0, hi_we, lo_we}, is_hi ? 64'd2 : 64'd1);
    check_val("mt_out", {hi_out, lo_out}, is_hi ? {a, 32'd0} : {32'd0, a});
    check_val("mt_stall", {63'd0, stallreq}, 64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0;
    #1;
    check_val("mt_after", {61'd0, stallreq, hi_we, lo_we}, 64'd0);
  endtask

  // Quiet window: no write enable and no stall may appear
  task automatic expect_quiet(input string tag, input int ncyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #2;
      if (stallreq !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0) seen = 1'b1;
    end
    check_val(tag, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic we_seen;
    int   r;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0; flush = 1'b0; ex_hold = 1'b0; op_valid = 1'b0;
    op = c_NONE; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #2;
    check_val("reset_ctl", {61'd0, stallreq, hi_we, lo_we}, 64'd0);
    check_val("reset_out", {hi_out, lo_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(c_MULT,  32'hFFFF_FFFD, 32'd7, 0);
    run_op(c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(c_DIVU,  32'd100, 32'd7, 0);
    run_op(c_DIV,   32'hFFFF_FFF9, 32'd2, 0);
    run_op(c_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(c_DIVU,  32'd5, 32'd0, 0);
    run_op(c_DIV,   32'hFFFF_FFF0, 32'd0, 1);
    run_op(c_MULT,  32'h8000_0000, 32'h8000_0000, 3);
    run_mt(c_MTHI,  32'h0000_1234);
    run_mt(c_MTLO,  32'hCAFE_F00D);

    // op NONE does nothing
    @(posedge clk); #1;
    op_valid = 1'b1; op = c_NONE; src_a = $urandom;
    #1;
    check_val("none_ctl", {61'd0, stallreq, hi_we, lo_we}, 64'd0);
    @(posedge clk); #1; op_valid = 1'b0;
    expect_quiet("none_quiet", 3);

    // Flush mid-divide
    @(posedge clk); #1;
    op_valid = 1'b1; op = c_DIV; src_a = 32'd1000; src_b = 32'd3;
    #1;
    check_val("flush_start_stall", {63'd0, stallreq}, 64'd1);
    we_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      if (hi_we !== 1'b0 || lo_we !== 1'b0) we_seen = 1'b1;
    end
    #1; flush = 1'b1;
    #1;
    check_val("flush_we", {62'd0, hi_we, lo_we}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    #1;
    check_val("flush_idle", {63'd0, stallreq}, 64'd0);
    check_val("flush_no_we_before", {63'd0, we_seen}, 64'd0);
    expect_quiet("flush_quiet", 40);

    // Flush beats a start, including MTHI
    @(posedge clk); #1;
    op_valid = 1'b1; op = c_MULT; src_a = 32'd9; src_b = 32'd9; flush = 1'b1;
    #1;
    check_val("flush_prio_stall", {63'd0, stallreq}, 64'd0);
    op = c_MTHI;
    #1;
    check_val("flush_prio_mthi", {62'd0, hi_we, lo_we}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    expect_quiet("flush_prio_quiet", 3);

    // Async reset mid-divide
    @(posedge clk); #1;
    op_valid = 1'b1; op = c_DIV; src_a = 32'hFFFF_0000; src_b = 32'd77;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0; op_valid = 1'b0;
    #1;
    check_val("rst_mid_ctl", {61'd0, stallreq, hi_we, lo_we}, 64'd0);
    check_val("rst_mid_out", {hi_out, lo_out}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_quiet("rst_mid_quiet", 40);

    // Randomized mix
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 9);
      ra = $urandom;
      rb = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
      if (r < 8) begin
        ro = 3'(1 + (r % 4));
        run_op(ro, ra, rb, $urandom_range(0, 2));
      end else if (r == 8) begin
        run_mt($urandom_range(0, 1) == 0 ? c_MTHI : c_MTLO, ra);
      end else begin
        run_mt(c_MTLO, rb);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
